execute_md: RTL and testbench

- Parametrised EX stage of the 5-stage RV32 pipeline. Sits between the ID/EX register and the MEM stage.
- Performs operand forwarding, SrcA/SrcB selection, ALU operation, branch/jump resolution and PCTarget generation, and owns the EX/MEM pipeline register.
- Adds an iterative RV32M multiply/divide unit. Its busy flag stalls the front of the pipeline while a M-extension op runs.

---
 rtl/execute_md.sv | 244 ++++++++++++++++++++++++
 tb/tb_execute_md.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_md.sv
// EX stage with operand forwarding, ALU, branch resolution, EX/MEM register
// and an iterative RV32M multiply/divide unit that stalls the front end.
module execute_md #(
  parameter int XLEN              = 32,
  parameter int MD_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Stall,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ALUSrcAE,
  input  logic            ALUSrcBE,
  input  logic            MulDivE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUCtrlE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] inc_PCE,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardA,
  input  logic [1:0]      ForwardB,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUoutM_i,
  output logic [XLEN-1:0] PCTarget,
  output logic            PCSrc,
  output logic            MDBusy,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUoutM_o,
  output logic [XLEN-1:0] Rd2M,
  output logic [XLEN-1:0] inc_PCM,
  output logic [2:0]      funct3M,
  output logic [4:0]      RdM
);

  localparam int N_ITER = XLEN / MD_BITS_PER_CYCLE;
  localparam int CW     = $clog2(N_ITER);
  localparam int SW     = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

  logic [XLEN-1:0] rs1, rs2, srca, srcb, alu_y;
  logic [SW-1:0]   shamt;
  logic            rel;

  always_comb begin
    unique case (ForwardA)
      2'b00:   rs1 = RD1E;
      2'b01:   rs1 = ResultW;
      2'b10:   rs1 = ALUoutM_i;
      default: rs1 = '0;
    endcase
    unique case (ForwardB)
      2'b00:   rs2 = RD2E;
      2'b01:   rs2 = ResultW;
      2'b10:   rs2 = ALUoutM_i;
      default: rs2 = '0;
    endcase
  end

  assign srca  = ALUSrcAE ? PCE : rs1;
  assign srcb  = ALUSrcBE ? ImmExtE : rs2;
  assign shamt = srcb[SW-1:0];

  always_comb begin
    alu_y = '0;
    case (ALUCtrlE)
      4'd0:    alu_y = srca + srcb;
      4'd1:    alu_y = srca - srcb;
      4'd2:    alu_y = srca & srcb;
      4'd3:    alu_y = srca | srcb;
      4'd4:    alu_y = srca ^ srcb;
      4'd5:    alu_y = {{(XLEN-1){1'b0}},
                        $signed(srca) < $signed(srcb)};
      4'd6:    alu_y = {{(XLEN-1){1'b0}}, srca < srcb};
      4'd7:    alu_y = srca << shamt;
      4'd8:    alu_y = srca >> shamt;
      4'd9:    alu_y = XLEN'($signed(srca) >>> shamt);
      4'd10:   alu_y = srcb;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    rel = 1'b0;
    case (funct3E)
      3'b000:  rel = (rs1 == rs2);
      3'b001:  rel = (rs1 != rs2);
      3'b100:  rel = $signed(rs1) < $signed(rs2);
      3'b101:  rel = $signed(rs1) >= $signed(rs2);
      3'b110:  rel = rs1 < rs2;
      3'b111:  rel = rs1 >= rs2;
      default: rel = 1'b0;
    endcase
  end

  assign PCTarget = alu_y;
  assign PCSrc    = (BranchE & rel) | JumpE;

  md_state_t         state, state_nx;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] p, p_nx, prod;
  logic [XLEN-1:0]   d, mag_a, mag_b, quo, rem, md_y;
  logic [XLEN:0]     trial, sum;
  logic [2:0]        op;
  logic              sa, sb, dz, sgn_a, sgn_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    MDBusy   = 1'b0;
    case (state)
      IDLE: begin
        if (MulDivE) begin
          MDBusy   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        MDBusy = 1'b1;
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        if (!Stall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // signed operands: MULH/MULHSU/DIV/REM on rs1, MULH/DIV/REM on rs2
  assign sgn_a = rs1[XLEN-1] & (funct3E == 3'b001 || funct3E == 3'b010 ||
                                funct3E == 3'b100 || funct3E == 3'b110);
  assign sgn_b = rs2[XLEN-1] & (funct3E == 3'b001 || funct3E == 3'b100 ||
                                funct3E == 3'b110);
  assign mag_a = sgn_a ? -rs1 : rs1;
  assign mag_b = sgn_b ? -rs2 : rs2;

  always_comb begin
    p_nx  = p;
    trial = '0;
    sum   = '0;
    for (int i = 0; i < MD_BITS_PER_CYCLE; i++) begin
      if (op[2]) begin
        trial = p_nx[2*XLEN-1:XLEN-1] - {1'b0, d};
        if (!trial[XLEN])
          p_nx = {trial[XLEN-1:0], p_nx[XLEN-2:0], 1'b1};
        else
          p_nx = {p_nx[2*XLEN-2:0], 1'b0};
      end else begin
        sum  = {1'b0, p_nx[2*XLEN-1:XLEN]} + (p_nx[0] ? {1'b0, d} : '0);
        p_nx = {sum, p_nx[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      p   <= '0;
      d   <= '0;
      op  <= '0;
      sa  <= 1'b0;
      sb  <= 1'b0;
      dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MulDivE) begin
            p   <= {{XLEN{1'b0}}, mag_a};
            d   <= mag_b;
            op  <= funct3E;
            sa  <= sgn_a;
            sb  <= sgn_b;
            dz  <= (rs2 == '0);
            cnt <= CW'(N_ITER - 1);
          end
        end
        RUN: begin
          p <= p_nx;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prod = (sa ^ sb) ? -p : p;
    quo  = (sa ^ sb) ? -p[XLEN-1:0] : p[XLEN-1:0];
    if (dz) quo = '1;
    rem  = sa ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    if (op[2])
      md_y = op[1] ? rem : quo;
    else if (op[1:0] == 2'b00)
      md_y = prod[XLEN-1:0];
    else
      md_y = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUoutM_o  <= '0;
      Rd2M       <= '0;
      inc_PCM    <= '0;
      funct3M    <= '0;
      RdM        <= '0;
    end else if (Stall) begin
      RegWriteM  <= RegWriteM;
    end else if (MDBusy) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUoutM_o  <= '0;
      Rd2M       <= '0;
      inc_PCM    <= '0;
      funct3M    <= '0;
      RdM        <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUoutM_o  <= (state == DONE) ? md_y : alu_y;
      Rd2M       <= rs2;
      inc_PCM    <= inc_PCE;
      funct3M    <= funct3E;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: forwarding, branches, RV32M ops,
// stall in DONE, reset mid-run and a 4-bit-per-cycle instance.
module tb_execute_md;

  logic        clk, rst_n, Stall;
  logic        JumpE, BranchE, RegWriteE, MemWriteE;
  logic        ALUSrcAE, ALUSrcBE, MulDivE, MulDivE4;
  logic [1:0]  ResultSrcE, ForwardA, ForwardB;
  logic [3:0]  ALUCtrlE;
  logic [2:0]  funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, inc_PCE, ResultW, ALUoutM_i;
  logic [4:0]  RdE;

  logic [31:0] PCTarget0, ALUoutM0, Rd2M0, inc_PCM0;
  logic        PCSrc0, MDBusy0, RegWriteM0, MemWriteM0;
  logic [1:0]  ResultSrcM0;
  logic [2:0]  funct3M0;
  logic [4:0]  RdM0;

  logic [31:0] PCTarget4, ALUoutM4, Rd2M4, inc_PCM4;
  logic        PCSrc4, MDBusy4, RegWriteM4, MemWriteM4;
  logic [1:0]  ResultSrcM4;
  logic [2:0]  funct3M4;
  logic [4:0]  RdM4;

  int n_cmp = 0;
  int n_bad = 0;

  execute_md #(.XLEN(32), .MD_BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .Stall(Stall),
    .JumpE(JumpE), .BranchE(BranchE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .MulDivE(MulDivE), .ResultSrcE(ResultSrcE), .ALUCtrlE(ALUCtrlE),
    .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .inc_PCE(inc_PCE), .RdE(RdE),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .ResultW(ResultW), .ALUoutM_i(ALUoutM_i),
    .PCTarget(PCTarget0), .PCSrc(PCSrc0), .MDBusy(MDBusy0),
    .RegWriteM(RegWriteM0), .MemWriteM(MemWriteM0),
    .ResultSrcM(ResultSrcM0), .ALUoutM_o(ALUoutM0), .Rd2M(Rd2M0),
    .inc_PCM(inc_PCM0), .funct3M(funct3M0), .RdM(RdM0)
  );

  execute_md #(.XLEN(32), .MD_BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .Stall(Stall),
    .JumpE(JumpE), .BranchE(BranchE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .MulDivE(MulDivE4), .ResultSrcE(ResultSrcE), .ALUCtrlE(ALUCtrlE),
    .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .inc_PCE(inc_PCE), .RdE(RdE),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .ResultW(ResultW), .ALUoutM_i(ALUoutM_i),
    .PCTarget(PCTarget4), .PCSrc(PCSrc4), .MDBusy(MDBusy4),
    .RegWriteM(RegWriteM4), .MemWriteM(MemWriteM4),
    .ResultSrcM(ResultSrcM4), .ALUoutM_o(ALUoutM4), .Rd2M(Rd2M4),
    .inc_PCM(inc_PCM4), .funct3M(funct3M4), .RdM(RdM4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_sel(input bit s);
    return s ? MDBusy4 : MDBusy0;
  endfunction

  function automatic logic rw_sel(input bit s);
    return s ? RegWriteM4 : RegWriteM0;
  endfunction

  function automatic logic [31:0] out_sel(input bit s);
    return s ? ALUoutM4 : ALUoutM0;
  endfunction

  task automatic set_m(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
    RD1E = a; RD2E = b; funct3E = f3;
    ForwardA = 2'b00; ForwardB = 2'b00;
    ALUSrcAE = 1'b0; ALUSrcBE = 1'b0;
    BranchE = 1'b0; JumpE = 1'b0;
    RegWriteE = 1'b1; MemWriteE = 1'b0;
    RdE = 5'd9; ALUCtrlE = 4'd0; Stall = 1'b0;
  endtask

  task automatic run_m(input bit s, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat,
                       input string tag);
    int n;
    set_m(f3, a, b);
    if (s) MulDivE4 = 1'b1;
    else   MulDivE  = 1'b1;
    #1;
    n = 0;
    while (busy_sel(s) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_bubble"}, {31'd0, rw_sel(s)}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_res"}, out_sel(s), exp);
    chk({tag, "_rw"}, {31'd0, rw_sel(s)}, 32'd1);
    MulDivE  = 1'b0;
    MulDivE4 = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; Stall = 1'b0;
    JumpE = 0; BranchE = 0; RegWriteE = 0; MemWriteE = 0;
    ALUSrcAE = 0; ALUSrcBE = 0; MulDivE = 0; MulDivE4 = 0;
    ResultSrcE = 0; ForwardA = 0; ForwardB = 0; ALUCtrlE = 0;
    funct3E = 0; RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0;
    inc_PCE = 0; ResultW = 0; ALUoutM_i = 0; RdE = 0;
    #2;
    chk("rst_alu", ALUoutM0, 32'd0);
    chk("rst_rw", {31'd0, RegWriteM0}, 32'd0);
    chk("rst_busy", {31'd0, MDBusy0}, 32'd0);
    chk("rst_misc", {31'd0, |{MemWriteM0, ResultSrcM0, Rd2M0, inc_PCM0,
                              funct3M0, RdM0, PCSrc0, PCTarget0}}, 32'd0);
    chk("rst4_all", {31'd0, |{ALUoutM4, RegWriteM4, MDBusy4, MemWriteM4,
                              ResultSrcM4, Rd2M4, inc_PCM4, funct3M4,
                              RdM4, PCSrc4, PCTarget4}}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD with rs1 forwarded from MEM
    RD1E = 32'd1; RD2E = 32'd3; ForwardA = 2'b10; ALUoutM_i = 32'd5;
    ALUCtrlE = 4'd0; RegWriteE = 1'b1; RdE = 5'd3; inc_PCE = 32'h44;
    #1;
    chk("add_busy", {31'd0, MDBusy0}, 32'd0);
    @(posedge clk); #1;
    chk("add_res", ALUoutM0, 32'd8);
    chk("add_rw", {31'd0, RegWriteM0}, 32'd1);
    chk("add_rd", {27'd0, RdM0}, 32'd3);
    chk("add_pc4", inc_PCM0, 32'h44);

    // SUB with rs2 forwarded from WB
    RD1E = 32'd10; ForwardA = 2'b00; ForwardB = 2'b01; ResultW = 32'd4;
    ALUCtrlE = 4'd1;
    @(posedge clk); #1;
    chk("sub_res", ALUoutM0, 32'd6);
    chk("sub_rd2", Rd2M0, 32'd4);

    // rs1 forced to zero, immediate operand
    ForwardA = 2'b11; ForwardB = 2'b00; ALUSrcBE = 1'b1;
    ImmExtE = 32'h55; ALUCtrlE = 4'd0;
    @(posedge clk); #1;
    chk("zero_imm", ALUoutM0, 32'h55);

    // branch resolution
    ForwardA = 2'b00; ALUSrcAE = 1'b1; ALUSrcBE = 1'b1;
    PCE = 32'h100; ImmExtE = 32'h20; BranchE = 1'b1;
    RD1E = 32'h1234; RD2E = 32'h1234; funct3E = 3'b000;
    #1;
    chk("beq_src", {31'd0, PCSrc0}, 32'd1);
    chk("beq_tgt", PCTarget0, 32'h120);
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; funct3E = 3'b100;
    #1;
    chk("blt_src", {31'd0, PCSrc0}, 32'd1);
    funct3E = 3'b110;
    #1;
    chk("bltu_src", {31'd0, PCSrc0}, 32'd0);
    funct3E = 3'b101;
    #1;
    chk("bge_src", {31'd0, PCSrc0}, 32'd0);
    BranchE = 1'b0; JumpE = 1'b1;
    #1;
    chk("jal_src", {31'd0, PCSrc0}, 32'd1);
    JumpE = 1'b0;
    @(posedge clk); #1;

    run_m(0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run_m(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33,
          "mulhu");
    run_m(0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33, "mulh");
    run_m(0, 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, "mulhsu");
    run_m(0, 3'b100, 32'd100, 32'd0, 32'hFFFF_FFFF, 33, "div0");
    run_m(0, 3'b110, 32'd100, 32'd0, 32'd100, 33, "rem0");
    run_m(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33,
          "divovf");
    run_m(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "removf");
    run_m(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "remneg");
    run_m(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "divneg");

    // stall while result waits in DONE
    set_m(3'b101, 32'd100, 32'd7);
    MulDivE = 1'b1;
    #1;
    n = 0;
    while (MDBusy0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_lat", n, 33);
    Stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_busy", {31'd0, MDBusy0}, 32'd0);
      chk("stall_hold", ALUoutM0, 32'd0);
    end
    Stall = 1'b0;
    @(posedge clk); #1;
    chk("stall_res", ALUoutM0, 32'd14);
    MulDivE = 1'b0;
    run_m(0, 3'b111, 32'd100, 32'd7, 32'd2, 33, "b2b");

    // reset during RUN
    set_m(3'b000, 32'd3, 32'd5);
    MulDivE = 1'b1;
    #1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, MDBusy0}, 32'd1);
    rst_n = 1'b0; MulDivE = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, MDBusy0}, 32'd0);
    chk("mid_rst_alu", ALUoutM0, 32'd0);
    #1;
    rst_n = 1'b1;
    RD1E = 32'd1; RD2E = 32'd3; ForwardA = 2'b10; ALUoutM_i = 32'd5;
    ALUCtrlE = 4'd0; RdE = 5'd4;
    #1;
    chk("post_busy", {31'd0, MDBusy0}, 32'd0);
    @(posedge clk); #1;
    chk("post_add", ALUoutM0, 32'd8);
    chk("post_rw", {31'd0, RegWriteM0}, 32'd1);

    // four bits per iteration
    run_m(1, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 9, "mul4");
    run_m(1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9,
          "mulhu4");
    run_m(1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 9,
          "divovf4");
    run_m(1, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 9, "remneg4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
